// File: rtl/m92_pkg.sv
// Shared types and helpers for the CPU/aux SDRAM arbiter.
package m92_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned BE_W   = 2;

  typedef enum logic [1:0] {
    StIdle,
    StCpuBus,
    StAuxBus,
    StDone
  } arb_state_t;

  typedef enum logic {
    ReqCpu,
    ReqAux
  } req_id_t;

  // On contention the preferred requester wins; otherwise whoever is asking.
  function automatic req_id_t pick_winner(input logic    cpu_req,
                                          input logic    aux_req,
                                          input req_id_t pref);
    if (cpu_req && aux_req) begin
      return pref;
    end
    return aux_req ? ReqAux : ReqCpu;
  endfunction

endpackage

// File: rtl/cpu_read_cache.sv
// Single-entry CPU read cache: one tagged word, filled on a CPU read miss and
// invalidated by any SDRAM write to the tagged address.
module cpu_read_cache
  import m92_pkg::*;
#(
  parameter int unsigned ADDR_W = 25
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data,
  input  logic              fill,
  input  logic              inval,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [DATA_W-1:0] fill_data
);

  logic              valid_q;
  logic [ADDR_W-1:0] tag_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (fill) begin
      valid_q <= 1'b1;
      tag_q   <= upd_addr;
      data_q  <= fill_data;
    end else if (inval && (upd_addr == tag_q)) begin
      valid_q <= 1'b0;
    end
  end

  always_comb begin
    hit      = valid_q && (tag_q == lookup_addr);
    hit_data = data_q;
  end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Two-requester SDRAM arbiter (CPU and aux/DMA), round robin on contention.
// Define CPU_READ_CACHE_EN to add a single-entry CPU read cache.
module cpu_mem_arbiter
  import m92_pkg::*;
#(
  parameter int unsigned ADDR_W    = 25,
  parameter int unsigned AUX_FIRST = 0
) (
  input  logic              clk_sys,
  input  logic              reset_n,

  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic              cpu_writable,
  input  logic [BE_W-1:0]   cpu_be,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,

  input  logic              aux_req,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic              aux_we,
  input  logic [BE_W-1:0]   aux_be,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic [DATA_W-1:0] aux_rdata,
  output logic              aux_ack,

  output logic              sdr_req,
  output logic [ADDR_W-1:0] sdr_addr,
  output logic              sdr_we,
  output logic [BE_W-1:0]   sdr_be,
  output logic [DATA_W-1:0] sdr_wdata,
  input  logic [DATA_W-1:0] sdr_rdata,
  input  logic              sdr_ack
);

  localparam req_id_t RrInit = (AUX_FIRST != 0) ? ReqAux : ReqCpu;

  arb_state_t        state_q;
  req_id_t           rr_q;     // winner of the next contested grant
  req_id_t           winner;
  logic              any_req;
  logic              cpu_blocked;
  logic              cpu_hit;
  logic              cache_hit;
  logic [DATA_W-1:0] cache_data;

`ifdef CPU_READ_CACHE_EN
  logic cache_fill;
  logic cache_inval;

  always_comb begin
    cache_fill  = (state_q == StCpuBus) && sdr_ack && !sdr_we;
    cache_inval = ((state_q == StCpuBus) || (state_q == StAuxBus)) && sdr_ack && sdr_we;
  end

  cpu_read_cache #(
    .ADDR_W(ADDR_W)
  ) u_cache (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .lookup_addr(cpu_addr),
    .hit        (cache_hit),
    .hit_data   (cache_data),
    .fill       (cache_fill),
    .inval      (cache_inval),
    .upd_addr   (sdr_addr),
    .fill_data  (sdr_rdata)
  );
`else
  assign cache_hit  = 1'b0;
  assign cache_data = '0;
`endif

  always_comb begin
    any_req     = cpu_req | aux_req;
    winner      = pick_winner(cpu_req, aux_req, rr_q);
    cpu_blocked = cpu_we & ~cpu_writable;
    cpu_hit     = ~cpu_we & cache_hit;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      rr_q      <= RrInit;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      aux_rdata <= '0;
      aux_ack   <= 1'b0;
      sdr_req   <= 1'b0;
      sdr_addr  <= '0;
      sdr_we    <= 1'b0;
      sdr_be    <= '0;
      sdr_wdata <= '0;
    end else begin
      cpu_ready <= 1'b0;
      aux_ack   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (any_req) begin
            if (cpu_req && aux_req) begin
              rr_q <= (winner == ReqCpu) ? ReqAux : ReqCpu;
            end
            if (winner == ReqCpu) begin
              if (cpu_blocked) begin
                // Write to a read-only region: complete without touching SDRAM.
                cpu_ready <= 1'b1;
                state_q   <= StDone;
              end else if (cpu_hit) begin
                cpu_ready <= 1'b1;
                cpu_rdata <= cache_data;
                state_q   <= StDone;
              end else begin
                sdr_req   <= 1'b1;
                sdr_addr  <= cpu_addr;
                sdr_we    <= cpu_we;
                sdr_be    <= cpu_be;
                sdr_wdata <= cpu_wdata;
                state_q   <= StCpuBus;
              end
            end else begin
              sdr_req   <= 1'b1;
              sdr_addr  <= aux_addr;
              sdr_we    <= aux_we;
              sdr_be    <= aux_be;
              sdr_wdata <= aux_wdata;
              state_q   <= StAuxBus;
            end
          end
        end
        StCpuBus: begin
          if (sdr_ack) begin
            sdr_req   <= 1'b0;
            cpu_rdata <= sdr_rdata;
            cpu_ready <= 1'b1;
            state_q   <= StDone;
          end
        end
        StAuxBus: begin
          if (sdr_ack) begin
            sdr_req   <= 1'b0;
            aux_rdata <= sdr_rdata;
            aux_ack   <= 1'b1;
            state_q   <= StDone;
          end
        end
        // One dead cycle lets the finished requester drop its request.
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model. Build with CPU_READ_CACHE_EN to cover the cache.
module tb_cpu_mem_arbiter;

  localparam int unsigned AW        = 25;
  localparam int unsigned AUX_FIRST = 0;
`ifdef CPU_READ_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic          cpu_req, cpu_we, cpu_writable, cpu_ready;
  logic [AW-1:0] cpu_addr;
  logic [1:0]    cpu_be;
  logic [15:0]   cpu_wdata, cpu_rdata;
  logic          aux_req, aux_we, aux_ack;
  logic [AW-1:0] aux_addr;
  logic [1:0]    aux_be;
  logic [15:0]   aux_wdata, aux_rdata;
  logic          sdr_req, sdr_we, sdr_ack;
  logic [AW-1:0] sdr_addr;
  logic [1:0]    sdr_be;
  logic [15:0]   sdr_wdata, sdr_rdata;

  cpu_mem_arbiter #(
    .ADDR_W   (AW),
    .AUX_FIRST(AUX_FIRST)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .cpu_req     (cpu_req),
    .cpu_addr    (cpu_addr),
    .cpu_we      (cpu_we),
    .cpu_writable(cpu_writable),
    .cpu_be      (cpu_be),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_ready   (cpu_ready),
    .aux_req     (aux_req),
    .aux_addr    (aux_addr),
    .aux_we      (aux_we),
    .aux_be      (aux_be),
    .aux_wdata   (aux_wdata),
    .aux_rdata   (aux_rdata),
    .aux_ack     (aux_ack),
    .sdr_req     (sdr_req),
    .sdr_addr    (sdr_addr),
    .sdr_we      (sdr_we),
    .sdr_be      (sdr_be),
    .sdr_wdata   (sdr_wdata),
    .sdr_rdata   (sdr_rdata),
    .sdr_ack     (sdr_ack)
  );

  initial forever #5 clk_sys = ~clk_sys;

  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  int            ack_delay = 3;
  int            n_sdr = 0;
  bit            stray_en = 1'b0;
  logic [AW-1:0] last_sdr_addr = '0;
  logic [15:0]   sdram   [logic [AW-1:0]];
  logic [15:0]   ref_mem [logic [AW-1:0]];
  logic [AW-1:0] pool [6];

  // Reference model state
  bit            aux_next;
  bit            c_valid;
  logic [AW-1:0] c_tag;
  logic [15:0]   c_data;
  logic [15:0]   cpu_rd_last;
  bit            cpu_rd_known;

  initial forever begin
    @(posedge clk_sys);
    cyc = cyc + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] cur, input logic [1:0] be,
                                        input logic [15:0] wd);
    return {be[1] ? wd[15:8] : cur[15:8], be[0] ? wd[7:0] : cur[7:0]};
  endfunction

  function automatic logic [15:0] rd_sdram(input logic [AW-1:0] a);
    return sdram.exists(a) ? sdram[a] : 16'h0;
  endfunction

  // SDRAM: acks in the ack_delay-th cycle of sdr_req; may inject stray acks when idle.
  initial begin : sdram_model
    int            cnt;
    logic [AW-1:0] a0;
    logic          we0;
    logic [1:0]    be0;
    logic [15:0]   wd0;
    cnt = 0; a0 = '0; we0 = 1'b0; be0 = '0; wd0 = '0;
    sdr_ack = 1'b0;
    sdr_rdata = '0;
    forever begin
      @(posedge clk_sys); #1;
      sdr_ack = 1'b0;
      if (!sdr_req) begin
        cnt = 0;
        if (stray_en && $urandom_range(0, 2) == 0) begin
          sdr_ack = 1'b1;
          sdr_rdata = 16'($urandom);
        end
      end else begin
        cnt++;
        if (cnt == 1) begin
          a0 = sdr_addr; we0 = sdr_we; be0 = sdr_be; wd0 = sdr_wdata;
          last_sdr_addr = sdr_addr;
        end else begin
          chk("sdr_fields_stable", {20'h0, sdr_addr, sdr_we, sdr_be, sdr_wdata},
              {20'h0, a0, we0, be0, wd0});
        end
        if (cnt == ack_delay) begin
          sdr_ack = 1'b1;
          n_sdr++;
          if (we0) sdram[a0] = merge(rd_sdram(a0), be0, wd0);
          else sdr_rdata = rd_sdram(a0);
        end
      end
    end
  end

  initial forever begin
    @(posedge clk_sys); #1;
    chk("single_owner", {63'h0, cpu_ready & aux_ack}, 64'h0);
  end

  // Transaction-level prediction: cost is edges from request to observed pulse.
  task automatic model_op(input bit is_aux, input logic [AW-1:0] a, input logic we,
                          input logic wr_ok, input logic [1:0] be, input logic [15:0] wd,
                          output int cost, output bit uses, output logic [15:0] exp_rd,
                          output bit chk_rd);
    logic [15:0] cur;
    cur = ref_mem.exists(a) ? ref_mem[a] : 16'h0;
    uses = 1'b1; exp_rd = cur; chk_rd = !we;
    if (!is_aux && we && !wr_ok) begin
      uses = 1'b0; exp_rd = cpu_rd_last; chk_rd = cpu_rd_known;
    end else if (!is_aux && !we && CACHE_EN && c_valid && c_tag == a) begin
      uses = 1'b0; exp_rd = c_data;
    end else if (we) begin
      ref_mem[a] = merge(cur, be, wd);
      if (c_valid && c_tag == a) c_valid = 1'b0;
      if (!is_aux) cpu_rd_known = 1'b0;
    end else if (!is_aux && CACHE_EN) begin
      c_valid = 1'b1; c_tag = a; c_data = cur;
    end
    if (!is_aux && !we) begin
      cpu_rd_last = exp_rd; cpu_rd_known = 1'b1;
    end
    cost = uses ? ack_delay + 1 : 1;
  endtask

  task automatic do_op(input bit is_aux, input logic [AW-1:0] a, input logic we,
                       input logic wr_ok, input logic [1:0] be, input logic [15:0] wd,
                       input bit scramble, output int lat, output logic [15:0] rd);
    int start;
    lat = -1; rd = '0;
    if (is_aux) begin
      aux_addr = a; aux_we = we; aux_be = be; aux_wdata = wd; aux_req = 1'b1;
    end else begin
      cpu_addr = a; cpu_we = we; cpu_writable = wr_ok; cpu_be = be; cpu_wdata = wd;
      cpu_req = 1'b1;
    end
    start = cyc;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk_sys); #1;
      if (scramble && i == 0) begin
        if (is_aux) begin
          aux_addr = ~a; aux_wdata = ~wd; aux_be = ~be;
        end else begin
          cpu_addr = ~a; cpu_wdata = ~wd; cpu_be = ~be; cpu_writable = ~wr_ok;
        end
      end
      if (is_aux ? aux_ack : cpu_ready) begin
        lat = cyc - start;
        rd = is_aux ? aux_rdata : cpu_rdata;
        break;
      end
    end
    if (is_aux) aux_req = 1'b0;
    else cpu_req = 1'b0;
    @(posedge clk_sys); #1;
    chk(is_aux ? "aux_ack_width" : "cpu_ready_width",
        {63'h0, is_aux ? aux_ack : cpu_ready}, 64'h0);
  endtask

  task automatic run_single(input bit is_aux, input logic [AW-1:0] a, input logic we,
                            input logic wr_ok, input logic [1:0] be, input logic [15:0] wd,
                            input bit scramble);
    int cost, lat, sdr0;
    bit uses, ck;
    logic [15:0] exp_rd, rd;
    string who;
    who = is_aux ? "aux" : "cpu";
    model_op(is_aux, a, we, wr_ok, be, wd, cost, uses, exp_rd, ck);
    sdr0 = n_sdr;
    do_op(is_aux, a, we, wr_ok, be, wd, scramble, lat, rd);
    chk({who, "_latency"}, 64'(lat), 64'(cost));
    if (ck) chk({who, "_rdata"}, {48'h0, rd}, {48'h0, exp_rd});
    chk({who, "_sdr_cycles"}, 64'(n_sdr - sdr0), {63'h0, uses});
  endtask

  task automatic run_pair(input logic [AW-1:0] ca, input logic cwe, input logic cwr,
                          input logic [1:0] cbe, input logic [15:0] cwd,
                          input logic [AW-1:0] aa, input logic awe,
                          input logic [1:0] abe, input logic [15:0] awd);
    bit aux_wins, cu, au, cck, ack_chk;
    int cc, ac, clat, alat, sdr0;
    logic [15:0] cexp, aexp, crd, ard;
    aux_wins = aux_next;
    aux_next = !aux_wins;
    if (aux_wins) begin
      model_op(1'b1, aa, awe, 1'b1, abe, awd, ac, au, aexp, ack_chk);
      model_op(1'b0, ca, cwe, cwr, cbe, cwd, cc, cu, cexp, cck);
      cc = ac + 1 + cc;
    end else begin
      model_op(1'b0, ca, cwe, cwr, cbe, cwd, cc, cu, cexp, cck);
      model_op(1'b1, aa, awe, 1'b1, abe, awd, ac, au, aexp, ack_chk);
      ac = cc + 1 + ac;
    end
    sdr0 = n_sdr;
    fork
      do_op(1'b0, ca, cwe, cwr, cbe, cwd, 1'b0, clat, crd);
      do_op(1'b1, aa, awe, 1'b1, abe, awd, 1'b0, alat, ard);
    join
    chk("pair_grant_order", {63'h0, alat < clat}, {63'h0, aux_wins});
    chk("pair_cpu_latency", 64'(clat), 64'(cc));
    chk("pair_aux_latency", 64'(alat), 64'(ac));
    if (cck) chk("pair_cpu_rdata", {48'h0, crd}, {48'h0, cexp});
    if (ack_chk) chk("pair_aux_rdata", {48'h0, ard}, {48'h0, aexp});
    chk("pair_sdr_cycles", 64'(n_sdr - sdr0), 64'(int'(cu) + int'(au)));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int            lat, cost, sdr0, kind;
    bit            uses, ck;
    logic [15:0]   rd, exp_rd, v;
    logic [AW-1:0] a1, a2;
    logic          we1, we2, wr1;
    logic [1:0]    be1, be2;
    logic [15:0]   wd1, wd2;

    reset_n = 1'b0;
    cpu_req = 1'b0; cpu_addr = '0; cpu_we = 1'b0; cpu_writable = 1'b1; cpu_be = '0;
    cpu_wdata = '0;
    aux_req = 1'b0; aux_addr = '0; aux_we = 1'b0; aux_be = '0; aux_wdata = '0;
    pool[0] = 25'h0012345;
    pool[1] = 25'h0000100;
    for (int i = 2; i < 6; i++) pool[i] = AW'($urandom) ^ AW'(i << 12);
    for (int i = 0; i < 6; i++) begin
      v = (i == 0) ? 16'hBEEF : 16'($urandom);
      sdram[pool[i]] = v;
      ref_mem[pool[i]] = v;
    end
    aux_next = (AUX_FIRST != 0);
    c_valid = 1'b0; c_tag = '0; c_data = '0;
    cpu_rd_last = '0; cpu_rd_known = 1'b1;

    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_sdr_req",   {63'h0, sdr_req},   64'h0);
    chk("rst_sdr_addr",  {39'h0, sdr_addr},  64'h0);
    chk("rst_sdr_we",    {63'h0, sdr_we},    64'h0);
    chk("rst_sdr_be",    {62'h0, sdr_be},    64'h0);
    chk("rst_sdr_wdata", {48'h0, sdr_wdata}, 64'h0);
    chk("rst_cpu_ready", {63'h0, cpu_ready}, 64'h0);
    chk("rst_cpu_rdata", {48'h0, cpu_rdata}, 64'h0);
    chk("rst_aux_ack",   {63'h0, aux_ack},   64'h0);
    chk("rst_aux_rdata", {48'h0, aux_rdata}, 64'h0);
    reset_n = 1'b1;
    @(posedge clk_sys); #1;

    // Read 0x0012345, ack after 3 cycles returning 0xBEEF.
    ack_delay = 3;
    run_single(1'b0, pool[0], 1'b0, 1'b1, 2'b11, 16'h0, 1'b0);
    chk("beef_sdr_addr", {39'h0, last_sdr_addr}, {39'h0, 25'h0012345});
    chk("beef_rdata", {48'h0, cpu_rdata}, {48'h0, 16'hBEEF});

    // Write to a non-writable region: no SDRAM cycle, rdata kept.
    run_single(1'b0, pool[2], 1'b1, 1'b0, 2'b11, 16'h1234, 1'b0);

    // Three simultaneous requests: CPU, AUX, CPU.
    ack_delay = 2;
    for (int i = 0; i < 3; i++) begin
      run_pair(pool[3], 1'b0, 1'b1, 2'b11, 16'h0, pool[4], 1'b0, 2'b11, 16'h0);
    end

    // CPU request withdrawn before it is granted.
    ack_delay = 4;
    model_op(1'b1, pool[5], 1'b0, 1'b1, 2'b11, 16'h0, cost, uses, exp_rd, ck);
    sdr0 = n_sdr;
    fork
      do_op(1'b1, pool[5], 1'b0, 1'b1, 2'b11, 16'h0, 1'b0, lat, rd);
      begin
        @(posedge clk_sys); #1;
        cpu_addr = pool[2]; cpu_we = 1'b0; cpu_req = 1'b1;
        repeat (2) begin
          @(posedge clk_sys); #1;
          chk("dropped_no_ready", {63'h0, cpu_ready}, 64'h0);
        end
        cpu_req = 1'b0;
      end
    join
    repeat (6) begin
      @(posedge clk_sys); #1;
      chk("dropped_no_ready", {63'h0, cpu_ready}, 64'h0);
    end
    chk("dropped_aux_latency", 64'(lat), 64'(cost));
    chk("dropped_aux_rdata", {48'h0, rd}, {48'h0, exp_rd});
    chk("dropped_sdr_cycles", 64'(n_sdr - sdr0), 64'h1);

    // Read 0x100 twice, aux write, read again.
    ack_delay = 2;
    run_single(1'b0, pool[1], 1'b0, 1'b1, 2'b11, 16'h0, 1'b0);
    run_single(1'b0, pool[1], 1'b0, 1'b1, 2'b11, 16'h0, 1'b0);
    run_single(1'b1, pool[1], 1'b1, 1'b1, 2'b11, 16'h5A5A, 1'b0);
    run_single(1'b0, pool[1], 1'b0, 1'b1, 2'b11, 16'h0, 1'b0);

    // Randomized traffic with stray acks and field changes after grant.
    for (int it = 0; it < 60; it++) begin
      ack_delay = $urandom_range(1, 4);
      stray_en  = ($urandom_range(0, 1) == 1);
      kind = $urandom_range(0, 2);
      a1 = pool[$urandom_range(0, 5)]; a2 = pool[$urandom_range(0, 5)];
      we1 = 1'($urandom_range(0, 1)); we2 = 1'($urandom_range(0, 1));
      wr1 = ($urandom_range(0, 3) != 0);
      be1 = 2'($urandom_range(0, 3)); be2 = 2'($urandom_range(0, 3));
      wd1 = 16'($urandom); wd2 = 16'($urandom);
      if (kind == 0) run_single(1'b0, a1, we1, wr1, be1, wd1, 1'($urandom_range(0, 1)));
      else if (kind == 1) run_single(1'b1, a2, we2, 1'b1, be2, wd2, 1'($urandom_range(0, 1)));
      else run_pair(a1, we1, wr1, be1, wd1, a2, we2, be2, wd2);
    end
    stray_en = 1'b0;

    // Reset mid-transfer: abandon with no pulse, then resume normally.
    ack_delay = 10;
    cpu_addr = pool[3]; cpu_we = 1'b0; cpu_writable = 1'b1; cpu_req = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("mid_sdr_req_high", {63'h0, sdr_req}, 64'h1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_sdr_req", {63'h0, sdr_req}, 64'h0);
    chk("mid_rst_cpu_ready", {63'h0, cpu_ready}, 64'h0);
    cpu_req = 1'b0;
    repeat (3) begin
      @(posedge clk_sys); #1;
      chk("mid_rst_no_ready", {63'h0, cpu_ready}, 64'h0);
    end
    reset_n = 1'b1;
    aux_next = (AUX_FIRST != 0);
    c_valid = 1'b0;
    cpu_rd_last = '0; cpu_rd_known = 1'b1;
    @(posedge clk_sys); #1;
    ack_delay = 2;
    run_single(1'b0, pool[3], 1'b0, 1'b1, 2'b11, 16'h0, 1'b0);
    run_pair(pool[4], 1'b0, 1'b1, 2'b11, 16'h0, pool[5], 1'b1, 2'b01, 16'hC3C3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_mem_arbiter.md
CPU_MEM_ARBITER -- requirements
Module: cpu_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 25: SDRAM word-address width, matching the sdr_addr width produced by the address translator.
REQ-002 SHALL have parameter AUX_FIRST, default 0: selects which requester wins the first simultaneous request after reset; 0 = CPU wins.
REQ-003 SHALL have port clk_sys  in  1: the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  in  1: asynchronous, active-low reset.
REQ-005 SHALL have port cpu_req  in  1: CPU access request, held high until cpu_ready.
REQ-006 SHALL have port cpu_addr  in  ADDR_W: translated SDRAM address.
REQ-007 SHALL have ports cpu_we, cpu_writable, cpu_be[1:0] and cpu_wdata[15:0], all inputs: write strobe, region-writable flag, byte enables and write data.
REQ-008 SHALL have ports cpu_rdata  out  16 and cpu_ready  out  1: read data, and a one-cycle completion pulse.
REQ-009 SHALL have ports aux_req  in  1, aux_addr  in  ADDR_W, aux_we  in  1, aux_be  in  2 and aux_wdata  in  16: second requester (download/DMA), held until aux_ack.
REQ-010 SHALL have ports aux_rdata  out  16 and aux_ack  out  1: aux read data, and a one-cycle completion pulse.
REQ-011 SHALL have ports sdr_req  out  1, sdr_addr  out  ADDR_W, sdr_we  out  1, sdr_be  out  2 and sdr_wdata  out  16: SDRAM channel request, held until sdr_ack.
REQ-012 SHALL have ports sdr_rdata  in  16 and sdr_ack  in  1: SDRAM read data, valid in the cycle sdr_ack is high.

Function
REQ-013 SHALL implement states IDLE, CPU_BUS, AUX_BUS and DONE.
REQ-014 IDLE: a pending request SHALL move to CPU_BUS or AUX_BUS, with sdr_req and the sdr_* fields registered high and valid in the next cycle.
REQ-015 When both requests are pending in IDLE, SHALL grant the requester that did not win the previous contested grant (round robin); the first contested grant follows AUX_FIRST.
REQ-016 SHALL hold sdr_addr, sdr_we, sdr_be and sdr_wdata stable while sdr_req is high.
REQ-017 In CPU_BUS or AUX_BUS, on sdr_ack SHALL drop sdr_req, register sdr_rdata into the owner's rdata, pulse the owner's ready/ack for exactly one cycle, and enter DONE.
REQ-018 DONE SHALL last one cycle and then return to IDLE, so that a still-high requester is not granted twice.
REQ-019 A CPU write with cpu_writable=0 SHALL issue no SDRAM cycle, SHALL pulse cpu_ready the cycle after acceptance, and SHALL leave cpu_rdata unchanged.
REQ-020 Minimum latency from request to completion SHALL be 1 cycle of request registration plus the SDRAM ack delay plus 1 cycle for the ready pulse.
REQ-021 SHALL sample a requester's fields only in the cycle it is granted; changes after the grant are ignored until that requester's completion.
REQ-022 An sdr_ack arriving in IDLE or DONE SHALL be ignored.
REQ-023 A request deasserted before it is granted SHALL be dropped with no pulse.

Reset
REQ-024 While reset_n is low: state = IDLE, all outputs 0, round-robin pointer set per AUX_FIRST, cache invalid.
REQ-025 Reset asserted mid-transfer SHALL abandon the transfer immediately with no ready/ack pulse; after release, operation SHALL resume from IDLE.

Configuration
REQ-026 Macro CPU_READ_CACHE_EN SHALL control a single-entry CPU read cache; when it is defined, the cache holds one word (tag = full cpu_addr, data, valid).
REQ-027 With CPU_READ_CACHE_EN, a CPU read hit in IDLE SHALL pulse cpu_ready next cycle with the cached data and no sdr_req; a miss SHALL fill the entry on sdr_ack.
REQ-028 With CPU_READ_CACHE_EN, any SDRAM write (CPU or aux) to the tagged address SHALL clear valid.
REQ-029 Without CPU_READ_CACHE_EN, every CPU read SHALL go to SDRAM and no cache storage SHALL exist.

Structure
REQ-030 The state enum arb_state_t and the requester-ID enum SHALL live in m92_pkg.
REQ-031 The cache SHALL be a sub-module cpu_read_cache, instantiated only under CPU_READ_CACHE_EN.

Verification
REQ-032 CPU read at 0x0012345 with sdr_ack after 3 cycles, returning 0xBEEF -> sdr_req high for cycles 1-3, then cpu_rdata=0xBEEF with a one-cycle cpu_ready.
REQ-033 cpu_req and aux_req rise together, three times in a row -> grants alternate CPU, AUX, CPU (AUX_FIRST=0); at no point are two owners active.
REQ-034 CPU write with cpu_writable=0 -> sdr_req stays 0 and cpu_ready pulses 1 cycle after the request.
REQ-035 reset_n pulled low while sdr_req is high -> sdr_req is 0 immediately with no cpu_ready; a new request after release completes normally.
REQ-036 With CPU_READ_CACHE_EN, read 0x100, read 0x100 again, aux writes 0x100, read 0x100 -> SDRAM cycles on the 1st and 3rd reads only; the 2nd completes in 1 cycle.
